// File: rtl/anc_fir_ctrl.sv
// ANC FIR sequencer: latches a sample set, launches the FIR, collects the
// result, supports weight scan-out, and tracks overrun/timeout errors.
`timescale 1ns/1ps
module anc_fir_ctrl #(
    parameter int TIMEOUT_CYC = 300,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                smp_valid,
    input  logic signed [15:0]  x_smp,
    input  logic signed [15:0]  e_smp,
    input  logic signed [15:0]  a_smp,
    input  logic [3:0]          mu_shift,
    input  logic                adapt_en,
    input  logic                scan_req,
    input  logic                err_clr,
    output logic signed [15:0]  fir_x_in,
    output logic signed [15:0]  fir_a_in,
    output logic signed [15:0]  fir_wadj,
    output logic                fir_go,
    input  logic                fir_done,
    input  logic signed [15:0]  fir_out,
    output logic                scan_en,
    output logic signed [15:0]  y_out,
    output logic                y_valid,
    output logic                busy,
    output logic                overrun,
    output logic                timeout_err,
    output logic [CNT_W-1:0]    drop_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, SCAN} state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   tcnt, tcnt_nxt;
    logic            latch, done_ok, tmo, drop;
    logic signed [15:0] wadj_nxt;

    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        latch     = 1'b0;
        done_ok   = 1'b0;
        tmo       = 1'b0;
        unique case (state)
            IDLE: begin
                // A pending sample has priority over a scan request
                if (smp_valid) begin
                    latch     = 1'b1;
                    state_nxt = LAUNCH;
                end else if (scan_req) begin
                    state_nxt = SCAN;
                end
            end
            LAUNCH: begin
                state_nxt = WAIT;
                tcnt_nxt  = '0;
            end
            WAIT: begin
                if (fir_done) begin
                    done_ok   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tcnt_nxt = tcnt + TW'(1);
                    if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                        tmo       = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            SCAN: begin
                if (!scan_req) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign drop     = smp_valid && (state != IDLE);
    assign wadj_nxt = adapt_en ? (e_smp >>> mu_shift) : 16'sd0;

    assign fir_go  = (state == LAUNCH);
    assign scan_en = (state == SCAN);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fir_x_in <= '0;
            fir_a_in <= '0;
            fir_wadj <= '0;
        end else if (latch) begin
            fir_x_in <= x_smp;
            fir_a_in <= a_smp;
            fir_wadj <= wadj_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_out   <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= done_ok;
            if (done_ok) y_out <= fir_out;
        end
    end

    // New error events beat a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            if (drop)         overrun <= 1'b1;
            else if (err_clr) overrun <= 1'b0;

            if (tmo)          timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;

            if (err_clr)
                drop_cnt <= drop ? CNT_W'(1) : '0;
            else if (drop && (drop_cnt != '1))
                drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_anc_fir_ctrl.sv
// Directed bench for anc_fir_ctrl: datapath latch, timeout, drops,
// scan arbitration and asynchronous reset abort.
`timescale 1ns/1ps
module tb_anc_fir_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        smp_valid;
    logic [15:0] x_smp, e_smp, a_smp;
    logic [3:0]  mu_shift;
    logic        adapt_en, scan_req, err_clr;
    logic [15:0] fir_x_in, fir_a_in, fir_wadj;
    logic        fir_go, fir_done;
    logic [15:0] fir_out;
    logic        scan_en;
    logic [15:0] y_out;
    logic        y_valid, busy, overrun, timeout_err;
    logic [7:0]  drop_cnt;

    int errs = 0;
    int nchk = 0;
    logic [15:0] exp_y;

    anc_fir_ctrl #(.TIMEOUT_CYC(20), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .smp_valid(smp_valid),
        .x_smp(x_smp), .e_smp(e_smp), .a_smp(a_smp),
        .mu_shift(mu_shift), .adapt_en(adapt_en),
        .scan_req(scan_req), .err_clr(err_clr),
        .fir_x_in(fir_x_in), .fir_a_in(fir_a_in),
        .fir_wadj(fir_wadj), .fir_go(fir_go),
        .fir_done(fir_done), .fir_out(fir_out),
        .scan_en(scan_en), .y_out(y_out), .y_valid(y_valid),
        .busy(busy), .overrun(overrun),
        .timeout_err(timeout_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample; returns one cycle later with the DUT in LAUNCH
    task automatic send(input logic [15:0] x, input logic [15:0] e,
                        input logic [15:0] a, input logic [3:0] mu,
                        input logic ad);
        x_smp = x; e_smp = e; a_smp = a;
        mu_shift = mu; adapt_en = ad;
        smp_valid = 1'b1;
        tick();
        smp_valid = 1'b0;
    endtask

    // From LAUNCH: enter WAIT, return result r
    task automatic finish(input logic [15:0] r);
        tick();
        fir_done = 1'b1; fir_out = r;
        tick();
        fir_done = 1'b0;
        exp_y = r;
    endtask

    initial begin
        rst_n = 1'b0; smp_valid = 1'b0;
        x_smp = '0; e_smp = '0; a_smp = '0;
        mu_shift = '0; adapt_en = 1'b0;
        scan_req = 1'b0; err_clr = 1'b0;
        fir_done = 1'b0; fir_out = '0;
        exp_y = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_go", fir_go, 0);
        chk("rst_y", y_out, 0);
        chk("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Basic sample flow
        send(16'h1000, 16'h4000, 16'h0010, 4'd3, 1'b1);
        chk("go_pulse", fir_go, 1);
        chk("x_latch", fir_x_in, 16'h1000);
        chk("a_latch", fir_a_in, 16'h0010);
        chk("wadj", fir_wadj, 16'h0800);
        tick();
        chk("go_once", fir_go, 0);
        chk("busy_wait", busy, 1);
        fir_done = 1'b1; fir_out = 16'h1234;
        tick();
        fir_done = 1'b0;
        chk("yv_1", y_valid, 1);
        chk("y_1", y_out, 16'h1234);
        chk("x_hold", fir_x_in, 16'h1000);
        tick();
        chk("yv_once", y_valid, 0);
        chk("y_keep", y_out, 16'h1234);
        exp_y = 16'h1234;

        // Shift boundaries
        send(16'h0001, 16'h8000, 16'h0000, 4'd15, 1'b1);
        chk("wadj_min15", fir_wadj, 16'hFFFF);
        finish(16'h0002);
        send(16'h0001, 16'hFFF1, 16'h0000, 4'd2, 1'b1);
        chk("wadj_floor", fir_wadj, 16'hFFFC);
        finish(16'h0003);
        send(16'h0001, 16'h4000, 16'h0000, 4'd1, 1'b0);
        chk("wadj_frz", fir_wadj, 16'h0000);
        finish(16'h0004);
        chk("y_4", y_out, 16'h0004);

        // fir_done in IDLE is ignored
        tick();
        fir_done = 1'b1; fir_out = 16'h5555;
        tick();
        fir_done = 1'b0;
        chk("idle_done_v", y_valid, 0);
        chk("idle_done_y", y_out, exp_y);

        // Timeout after 20 cycles in WAIT
        send(16'h0007, 16'h0000, 16'h0000, 4'd0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (y_valid) chk("tmo_yv", y_valid, 0);
        end
        chk("tmo_b19", busy, 1);
        chk("tmo_f19", timeout_err, 0);
        tick();
        chk("tmo_flag", timeout_err, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_y", y_out, exp_y);
        tick();
        chk("tmo_yv", y_valid, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("tmo_clr", timeout_err, 0);

        // Drops during WAIT, clear collides with a drop
        send(16'h0008, 16'h0000, 16'h0000, 4'd0, 1'b1);
        tick();
        smp_valid = 1'b1;
        tick(); tick(); tick();
        chk("drop3", drop_cnt, 3);
        chk("ovr3", overrun, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("drop_clr", drop_cnt, 1);
        chk("ovr_clr", overrun, 1);
        fir_done = 1'b1; fir_out = 16'h0ABC;
        tick();
        fir_done = 1'b0; smp_valid = 1'b0;
        chk("coinc_yv", y_valid, 1);
        chk("coinc_y", y_out, 16'h0ABC);
        chk("coinc_drop", drop_cnt, 2);
        exp_y = 16'h0ABC;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_all", {overrun, drop_cnt}, 0);

        // Sample and scan together: sample first
        scan_req = 1'b1;
        send(16'h0009, 16'h0000, 16'h0000, 4'd0, 1'b1);
        chk("arb_go", fir_go, 1);
        chk("arb_scan", scan_en, 0);
        tick();
        chk("arb_scanw", scan_en, 0);
        fir_done = 1'b1; fir_out = 16'h7777;
        tick();
        fir_done = 1'b0;
        chk("arb_yv", y_valid, 1);
        chk("arb_scani", scan_en, 0);
        tick();
        chk("scan_on", scan_en, 1);
        chk("scan_busy", busy, 1);
        smp_valid = 1'b1;
        tick();
        chk("scan_ovr", overrun, 1);
        chk("scan_drop", drop_cnt, 1);
        chk("scan_go", fir_go, 0);
        for (int i = 0; i < 299; i++) tick();
        smp_valid = 1'b0;
        chk("sat", drop_cnt, 8'hFF);
        chk("scan_hold", scan_en, 1);
        scan_req = 1'b0;
        tick();
        chk("scan_off", scan_en, 0);
        chk("scan_idle", busy, 0);

        // Asynchronous reset mid-WAIT
        send(16'h00AA, 16'h0100, 16'h00BB, 4'd0, 1'b1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_flags", {overrun, timeout_err, drop_cnt}, 0);
        chk("arst_ops", {fir_x_in, fir_a_in, fir_wadj}, 0);
        chk("arst_y", y_out, 0);
        tick();
        rst_n = 1'b1;
        fir_done = 1'b1; fir_out = 16'h3333;
        tick();
        fir_done = 1'b0;
        tick();
        chk("arst_yv", y_valid, 0);
        chk("arst_y2", y_out, 0);
        chk("arst_go", fir_go, 0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
